// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_master
//  Purpose  : Command-port driven Wishbone master issuing classic single-beat
//             or incrementing-burst cycles. Write data comes from an FWFT
//             supplier and read data leaves as a valid-qualified stream. A
//             per-beat ack watchdog aborts a cycle when the slave stalls.
//  Revision : 1.0  initial release
// ============================================================================
module wb_burst_master #(
    parameter int AW     = 30,
    parameter int DW     = 32,
    parameter int LW     = 8,
    parameter int TO_CYC = 1023,
    parameter int TOW    = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [AW-1:0]     cmd_addr_i,
    input  logic [LW-1:0]     cmd_len_i,
    input  logic [DW/8-1:0]   cmd_sel_i,
    input  logic [DW-1:0]     wdat_i,
    output logic              wdat_rd_o,
    output logic [DW-1:0]     rdat_o,
    output logic              rdat_vld_o,
    output logic              done_o,
    output logic              err_o,
    output logic [LW-1:0]     beats_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);

    localparam logic [1:0]     c_st_idle  = 2'd0;
    localparam logic [1:0]     c_st_bus   = 2'd1;
    localparam logic [1:0]     c_st_fin   = 2'd2;
    localparam logic [TOW-1:0] c_wd_last  = TOW'(TO_CYC - 1);
    localparam logic [TOW-1:0] c_wd_one   = TOW'(1);
    localparam logic [LW-1:0]  c_len_one  = LW'(1);
    localparam logic [AW-1:0]  c_addr_one = AW'(1);
    localparam logic [2:0]     c_cti_classic = 3'b000;
    localparam logic [2:0]     c_cti_incr    = 3'b010;
    localparam logic [2:0]     c_cti_end     = 3'b111;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            r_we;
    logic [DW/8-1:0] r_sel;
    logic [LW-1:0]   r_len;
    logic [AW-1:0]   r_cur_addr;
    logic [LW-1:0]   r_beats;
    logic [TOW-1:0]  r_wd;
    logic            r_err;
    logic [DW-1:0]   r_rdat;
    logic            r_rdat_vld;

    logic [LW-1:0]   w_beats_inc;
    logic            w_last;
    logic            w_wd_hit;

    assign w_beats_inc = r_beats + c_len_one;
    assign w_last      = (w_beats_inc == r_len);
    // The watchdog fires on the TO_CYC-th consecutive unacked strobe cycle.
    assign w_wd_hit    = (r_wd == c_wd_last);

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an ack always wins over a simultaneous watchdog hit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (cmd_valid_i) begin
                    w_next = (cmd_len_i == '0) ? c_st_fin : c_st_bus;
                end
            end
            c_st_bus: begin
                if (wb_ack_i) begin
                    if (w_last) begin
                        w_next = c_st_fin;
                    end
                end else if (w_wd_hit) begin
                    w_next = c_st_fin;
                end
            end
            c_st_fin: w_next = c_st_idle;
            default:  w_next = c_st_idle;
        endcase
    end

    // Command latch, beat/address counters, watchdog and read-data capture.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_len      <= '0;
            r_cur_addr <= '0;
            r_beats    <= '0;
            r_wd       <= '0;
            r_err      <= 1'b0;
            r_rdat     <= '0;
            r_rdat_vld <= 1'b0;
        end else begin
            r_rdat_vld <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid_i) begin
                        r_we       <= cmd_we_i;
                        r_sel      <= cmd_sel_i;
                        r_len      <= cmd_len_i;
                        r_cur_addr <= cmd_addr_i;
                        r_beats    <= '0;
                        r_wd       <= '0;
                        r_err      <= 1'b0;
                    end
                end
                c_st_bus: begin
                    if (wb_ack_i) begin
                        r_beats    <= w_beats_inc;
                        r_cur_addr <= r_cur_addr + c_addr_one;
                        r_wd       <= '0;
                        if (!r_we) begin
                            r_rdat     <= wb_dat_i;
                            r_rdat_vld <= 1'b1;
                        end
                    end else if (w_wd_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wd <= r_wd + c_wd_one;
                    end
                end
                default: ;
            endcase
        end
    end

    // State-decoded outputs; bus-facing fields are zero outside the bus phase.
    always_comb begin
        cmd_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        wb_addr_o   = '0;
        wb_dat_o    = '0;
        wb_cti_o    = c_cti_classic;
        wdat_rd_o   = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (r_state)
            c_st_idle: cmd_ready_o = !wb_rst_i;
            c_st_bus: begin
                wb_cyc_o  = 1'b1;
                wb_stb_o  = 1'b1;
                wb_addr_o = r_cur_addr;
                if (r_len == c_len_one) begin
                    wb_cti_o = c_cti_classic;
                end else if (w_last) begin
                    wb_cti_o = c_cti_end;
                end else begin
                    wb_cti_o = c_cti_incr;
                end
                if (r_we) begin
                    wb_dat_o  = wdat_i;
                    wdat_rd_o = wb_ack_i;
                end
            end
            c_st_fin: begin
                done_o = 1'b1;
                err_o  = r_err;
            end
            default: ;
        endcase
    end

    assign wb_we_o    = r_we;
    assign wb_sel_o   = r_sel;
    assign beats_o    = r_beats;
    assign rdat_o     = r_rdat;
    assign rdat_vld_o = r_rdat_vld;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_burst_master
//  Purpose  : Self-checking bench for wb_burst_master: directed scenarios plus
//             randomized commands against a behavioural slave/timeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_burst_master;

    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int TO  = 8;
    localparam int TOW = 4;
    localparam int SW  = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_we_i;
    logic [AW-1:0]   cmd_addr_i;
    logic [LW-1:0]   cmd_len_i;
    logic [SW-1:0]   cmd_sel_i;
    logic [DW-1:0]   wdat_i;
    logic            wdat_rd_o;
    logic [DW-1:0]   rdat_o;
    logic            rdat_vld_o;
    logic            done_o;
    logic            err_o;
    logic [LW-1:0]   beats_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [SW-1:0]   wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_burst_master #(
        .AW(AW), .DW(DW), .LW(LW), .TO_CYC(TO), .TOW(TOW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_addr_i (cmd_addr_i),
        .cmd_len_i  (cmd_len_i),
        .cmd_sel_i  (cmd_sel_i),
        .wdat_i     (wdat_i),
        .wdat_rd_o  (wdat_rd_o),
        .rdat_o     (rdat_o),
        .rdat_vld_o (rdat_vld_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .beats_o    (beats_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_addr_o  (wb_addr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cti_o   (wb_cti_o),
        .wb_ack_i   (wb_ack_i),
        .wb_dat_i   (wb_dat_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and play a slave that acks beat i after a chosen
    // number of wait states. hang_beat names a beat that is never acked.
    task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input int len,
                           input logic [SW-1:0] sel, input int fixed_wait,
                           input int hang_beat, input bit directed);
        logic [DW-1:0] rd_exp;
        logic [DW-1:0] d;
        logic [AW-1:0] exp_addr;
        logic [2:0]    exp_cti;
        bit            rd_pend;
        bit            timed_out;
        bit            ack_now;
        int            done_beats;
        int            n_cyc;
        rd_exp = '0; rd_pend = 0; timed_out = 0; done_beats = 0;
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_len_i   = LW'(len);
        cmd_sel_i   = sel;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        for (int i = 0; i < len && !timed_out; i++) begin
            exp_addr = addr + AW'(i);
            exp_cti  = (len == 1) ? 3'b000 : ((i == len - 1) ? 3'b111 : 3'b010);
            if (i == hang_beat)   n_cyc = TO;
            else if (fixed_wait >= 0) n_cyc = fixed_wait + 1;
            else                  n_cyc = $urandom_range(1, TO);
            for (int w = 0; w < n_cyc; w++) begin
                @(negedge clk);
                chk("bus_cyc", wb_cyc_o, 1);
                chk("bus_stb", wb_stb_o, 1);
                chk("bus_addr", wb_addr_o, exp_addr);
                chk("bus_cti", wb_cti_o, exp_cti);
                chk("bus_we", wb_we_o, we);
                chk("bus_sel", wb_sel_o, sel);
                chk("bus_done_low", done_o, 0);
                chk("rdat_vld", rdat_vld_o, rd_pend);
                if (rd_pend) chk("rdat", rdat_o, rd_exp);
                rd_pend = 0;
                wdat_i  = directed ? DW'(i + 1) : DW'($urandom);
                ack_now = (i != hang_beat) && (w == n_cyc - 1);
                d       = directed ? (32'hDEADBEEF + DW'(i)) : DW'($urandom);
                wb_ack_i = ack_now;
                wb_dat_i = d;
                #1;
                chk("wdat_rd", wdat_rd_o, ack_now && we);
                if (we) chk("wb_dat_o", wb_dat_o, wdat_i);
                @(posedge clk);
                #1 wb_ack_i = 1'b0;
                if (ack_now) begin
                    done_beats++;
                    if (!we) begin
                        rd_pend = 1;
                        rd_exp  = d;
                    end
                end
            end
            if (i == hang_beat) timed_out = 1;
        end
        @(negedge clk);
        chk("fin_cyc", wb_cyc_o, 0);
        chk("fin_stb", wb_stb_o, 0);
        chk("fin_done", done_o, 1);
        chk("fin_err", err_o, timed_out);
        chk("fin_beats", beats_o, LW'(done_beats));
        chk("fin_ready", cmd_ready_o, 0);
        chk("fin_rdat_vld", rdat_vld_o, rd_pend);
        if (rd_pend) chk("fin_rdat", rdat_o, rd_exp);
        @(negedge clk);
        chk("idle_done", done_o, 0);
        chk("idle_ready", cmd_ready_o, 1);
        chk("idle_cyc", wb_cyc_o, 0);
        chk("idle_rdat_vld", rdat_vld_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic exp_cyc [8];
        logic exp_done[8];
        int   hang;
        int   len;
        rst = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0;
        cmd_len_i = '0; cmd_sel_i = '0; wdat_i = '0; wb_ack_i = 1'b0; wb_dat_i = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_cti", wb_cti_o, 0);
        chk("rst_addr", wb_addr_o, 0);
        chk("rst_beats", beats_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdat_vld", rdat_vld_o, 0);
        chk("rst_wdat_rd", wdat_rd_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready_o, 1);

        // Directed scenarios.
        run_cmd(1'b1, 30'h100, 4, 4'hF, 0, -1, 1'b1);        // write burst
        run_cmd(1'b0, 30'h20, 1, 4'hF, 3, -1, 1'b1);         // read single
        run_cmd(1'b0, 30'h3FFFFFFE, 4, 4'h5, 0, -1, 1'b0);   // address wrap
        run_cmd(1'b0, 30'h40, 3, 4'hF, 0, 1, 1'b0);          // timeout
        run_cmd(1'b1, 30'h80, 2, 4'h3, TO - 1, -1, 1'b0);    // ack on watchdog cycle
        run_cmd(1'b1, 30'h123, 0, 4'hF, 0, -1, 1'b0);        // no-op

        // Reset in the middle of a burst after two acks.
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 30'h55;
        cmd_len_i = 8'd8; cmd_sel_i = 4'h3;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            wb_ack_i = 1'b1;
            @(posedge clk);
            #1 wb_ack_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cyc_before", wb_cyc_o, 1);
        @(negedge clk);
        chk("mid_rst_cyc", wb_cyc_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_ready", cmd_ready_o, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_after_done", done_o, 0);
        chk("mid_rst_after_ready", cmd_ready_o, 1);
        run_cmd(1'b0, 30'h200, 3, 4'hC, 1, -1, 1'b0);

        // Back-to-back len-2 reads with cmd_valid held high, zero-wait slave.
        exp_cyc  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 30'h300;
        cmd_len_i = 8'd2; cmd_sel_i = 4'hF;
        @(posedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("b2b_cyc", wb_cyc_o, exp_cyc[c]);
            chk("b2b_done", done_o, exp_done[c]);
            if (exp_done[c]) chk("b2b_beats", beats_o, 2);
            if (c == 6) cmd_valid_i = 1'b0;
            wb_ack_i = wb_stb_o;
            wb_dat_i = DW'($urandom);
            @(posedge clk);
            #1 wb_ack_i = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_ready", cmd_ready_o, 1);

        // Randomized commands.
        for (int k = 0; k < 16; k++) begin
            len  = $urandom_range(0, 6);
            hang = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
            run_cmd(1'($urandom_range(0, 1)), AW'($urandom), len, SW'($urandom), -1, hang, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
